// File: rtl/vga_pkg.sv
// vga_pkg: coordinate type and default 640x480@60 raster timing
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL      = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL      = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
    localparam int V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/vga_mod_counter.sv
// vga_mod_counter: mod-N counter with enable, sync reset and registered wrap flag
module vga_mod_counter
    import vga_pkg::*;
#(
    parameter int N = 800
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output coord_t count_next,
    output logic   wrap
);

    localparam coord_t LAST = coord_t'(N - 1);

    coord_t count_d, count_q;
    logic   wrap_d, wrap_q;

    // next count, and whether that value is the terminal one
    always_comb begin
        count_d = en ? (wrap_q ? '0 : count_q + 10'd1) : count_q;
        wrap_d  = count_d == LAST;
    end

    // count and wrap-flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= LAST == '0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;
    assign wrap       = wrap_q;

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing; VGA_TICK_DIV_EN selects the divide-by-2 pixel tick
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       vblank_start
);

    localparam int     H_TOT  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int     V_TOT  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam coord_t H_VIS  = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS  = coord_t'(V_DISPLAY);
    localparam coord_t HS_BEG = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_END = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam coord_t VS_BEG = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_END = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);

    logic   tick, h_wrap, v_wrap_unused;
    coord_t h_cnt, h_next, v_cnt, v_next;
    logic   hsync_d, hsync_q, vsync_d, vsync_q;
    logic   video_on_d, video_on_q, vblank_start_d, vblank_start_q;

`ifdef VGA_TICK_DIV_EN
    logic phase_d, phase_q;

    // divide-by-2 phase: tick low in the first cycle after reset, then alternating
    always_ff @(posedge clk) begin
        phase_q <= rst ? 1'b0 : phase_d;
    end

    assign phase_d = ~phase_q;
    assign tick    = phase_q;
`else
    assign tick = 1'b1;
`endif

    vga_mod_counter #(.N(H_TOT)) u_h (
        .clk        (clk),
        .rst        (rst),
        .en         (tick),
        .count      (h_cnt),
        .count_next (h_next),
        .wrap       (h_wrap)
    );

    vga_mod_counter #(.N(V_TOT)) u_v (
        .clk        (clk),
        .rst        (rst),
        .en         (tick & h_wrap),
        .count      (v_cnt),
        .count_next (v_next),
        .wrap       (v_wrap_unused)
    );

    // decode from next-state counts so flags change on the same edge as the counters
    always_comb begin
        hsync_d        = !(h_next >= HS_BEG && h_next < HS_END);
        vsync_d        = !(v_next >= VS_BEG && v_next < VS_END);
        video_on_d     = h_next < H_VIS && v_next < V_VIS;
        vblank_start_d = tick && h_wrap && v_next == V_VIS;
    end

    // registered sync and flag outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q        <= 1'b1;
            vsync_q        <= 1'b1;
            video_on_q     <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            video_on_q     <= video_on_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign pixel_tick   = tick;
    assign pixel_x      = h_cnt;
    assign pixel_y      = v_cnt;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign video_on     = video_on_q;
    assign vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized bench for vga_sync_gen against a tick-count model; honours VGA_TICK_DIV_EN
module tb_vga_sync_gen;

    localparam int HV = 640, HF = 16, HSW = 96, HB = 48;
    localparam int VV = 8, VF = 2, VSW = 2, VB = 2;
    localparam int HT = HV + HF + HSW + HB;
    localparam int VT = VV + VF + VSW + VB;
`ifdef VGA_TICK_DIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pixel_tick, hsync, vsync, video_on, vblank_start;
    logic [9:0] pixel_x, pixel_y;

    int    checks = 0;
    int    failures = 0;
    int    k = 0;
    longint cyc = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_DISPLAY(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_DISPLAY(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_tick   (pixel_tick),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .hsync        (hsync),
        .vsync        (vsync),
        .video_on     (video_on),
        .vblank_start (vblank_start)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // expected outputs after kk clk edges since reset, from tick count alone
    function automatic logic [24:0] model(input int kk);
        int n, x, y;
        logic t, vo, hs, vs, vb;
        n  = kk / DIV;
        x  = n % HT;
        y  = (n / HT) % VT;
        t  = (kk % DIV) == DIV - 1;
        vo = kk > 0 && x < HV && y < VV;
        hs = !(x >= HV + HF && x < HV + HF + HSW);
        vs = !(y >= VV + VF && y < VV + VF + VSW);
        vb = kk > 0 && (kk % DIV) == 0 && x == 0 && y == VV;
        return {t, 10'(x), 10'(y), hs, vs, vo, vb};
    endfunction

    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        k = r ? 0 : k + 1;
        check_eq("outs", 32'({pixel_tick, pixel_x, pixel_y, hsync, vsync, video_on, vblank_start}), 32'(model(k)));
    endtask

    initial begin
        int n, y0, ticks, vmin, vmax;
        longint c0;
        logic seen_wrap;
        logic [9:0] px, py;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            check_eq("rst_x", 32'(pixel_x), 0);
            check_eq("rst_y", 32'(pixel_y), 0);
            check_eq("rst_hsync", 32'(hsync), 1);
            check_eq("rst_vsync", 32'(vsync), 1);
            check_eq("rst_video_on", 32'(video_on), 0);
            check_eq("rst_vblank", 32'(vblank_start), 0);
        end
        k = 0;
        step(0);
        check_eq("video_on_after_release", 32'(video_on), 1);
        n = 0;
        while (pixel_x == 0 && n < 4) begin step(0); n++; end
        check_eq("x_after_first_tick", 32'(pixel_x), 1);
        n = 0;
        while (hsync && n < 2 * HT * DIV) begin step(0); n++; end
        check_eq("hsync_start_x", 32'(pixel_x), HV + HF);
        n = 0;
        while (!hsync && n < 2 * HT * DIV) begin step(0); n++; end
        check_eq("hsync_end_x", 32'(pixel_x), HV + HF + HSW);
        check_eq("hsync_low_clks", 32'(n), HSW * DIV);
        n = 0;
        while (pixel_x != HT - 1 && n < 2 * HT * DIV) begin step(0); n++; end
        y0 = int'(pixel_y);
        n = 0;
        while (pixel_x == HT - 1 && n < 4) begin step(0); n++; end
        check_eq("line_wrap_x", 32'(pixel_x), 0);
        check_eq("line_wrap_y", 32'(pixel_y), 32'(y0 + 1));
        n = 0;
        while (pixel_y != VV && n < 2 * HT * VT * DIV) begin step(0); n++; end
        check_eq("vblank_y", 32'(pixel_y), VV);
        check_eq("vblank_x", 32'(pixel_x), 0);
        check_eq("video_off_at_vdisplay", 32'(video_on), 0);
        check_eq("vblank_pulse", 32'(vblank_start), 1);
        c0 = cyc;
        ticks = int'(pixel_tick);
        step(0);
        check_eq("vblank_one_clk", 32'(vblank_start), 0);
        vmin = VT;
        vmax = -1;
        seen_wrap = 1'b0;
        n = 0;
        do begin
            px = pixel_x;
            py = pixel_y;
            ticks += int'(pixel_tick);
            step(0);
            n++;
            if (!vsync) begin
                if (int'(pixel_y) < vmin) vmin = int'(pixel_y);
                if (int'(pixel_y) > vmax) vmax = int'(pixel_y);
            end
            if (px == HT - 1 && py == VT - 1 && pixel_x != px) begin
                seen_wrap = 1'b1;
                check_eq("frame_wrap_xy", 32'({pixel_x, pixel_y}), 0);
            end
        end while (!vblank_start && n < 2 * HT * VT * DIV);
        check_eq("frame_clks", 32'(cyc - c0), HT * VT * DIV);
        check_eq("frame_ticks", 32'(ticks), HT * VT);
        check_eq("vsync_first_line", 32'(vmin), VV + VF);
        check_eq("vsync_last_line", 32'(vmax), VV + VF + VSW - 1);
        check_eq("frame_wrap_seen", 32'(seen_wrap), 1);
        n = 0;
        while (!(pixel_x == 300 && pixel_y == 5 && pixel_tick) && n < 2 * HT * VT * DIV) begin step(0); n++; end
        check_eq("reach_300_5_x", 32'(pixel_x), 300);
        check_eq("reach_300_5_y", 32'(pixel_y), 5);
        step(1);
        check_eq("midrst_x", 32'(pixel_x), 0);
        check_eq("midrst_y", 32'(pixel_y), 0);
        check_eq("midrst_hsync", 32'(hsync), 1);
        check_eq("midrst_vsync", 32'(vsync), 1);
        check_eq("midrst_video_on", 32'(video_on), 0);
        for (int e = 0; e < 6; e++) begin
            repeat ($urandom_range(1, 3)) step(1);
            repeat ($urandom_range(1, 1200)) step(0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
